// File: rtl/iiitb_vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_vm_pkg
// Purpose  : Shared types for the vending FSM and its dispenser back end:
//            change codes, dispenser state encoding and the request entry.
// Revision : 1.0 - initial release
// ============================================================================
package iiitb_vm_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROD  = 3'd2,
    ST_CHG   = 3'd3,
    ST_FAULT = 3'd4
  } disp_state_e;

  typedef struct packed {
    logic       vend;
    logic [1:0] chg;
  } req_t;

  // Code 11 carries no change, so it is folded to CHG_NONE on entry.
  function automatic req_t make_req(input logic vend, input logic [1:0] chg);
    req_t r;
    r.vend = vend;
    r.chg  = (chg == 2'b11) ? CHG_NONE : chg;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iiitb_vm_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_vm_req_fifo
// Purpose  : Small synchronous request FIFO. A push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_vm_req_fifo
  import iiitb_vm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  req_t           mem_q [DEPTH];
  logic [AW:0]    wr_q;
  logic [AW:0]    rd_q;
  logic           w_do_push;
  logic           w_do_pop;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = mem_q[rd_q[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + 1'b1;
      if (w_do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock_i) begin
    if (w_do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/iiitb_vm_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_vm_dispenser
// Purpose  : Drives the product motor and coin ejectors from buffered vend
//            results, waits for sense feedback, tracks inventory and faults.
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_vm_dispenser
  import iiitb_vm_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 8,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 8,
  parameter int PROD_INIT    = 16,
  parameter int COIN5_INIT   = 32,
  parameter int COIN10_INIT  = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             out_i,
  input  logic [1:0]       change_i,
  input  logic             prod_sense_i,
  input  logic             coin_sense_i,
  input  logic             refill_i,
  output logic             prod_motor_o,
  output logic             coin5_eject_o,
  output logic             coin10_eject_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             fault_o,
  output logic             prod_empty_o,
  output logic [CNT_W-1:0] prod_count_o,
  output logic [CNT_W-1:0] coin5_count_o,
  output logic [CNT_W-1:0] coin10_count_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    C_T_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    C_PULSE    = CW'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_PROD_INI = CNT_W'(PROD_INIT);
  localparam logic [CNT_W-1:0] C_C5_INI   = CNT_W'(COIN5_INIT);
  localparam logic [CNT_W-1:0] C_C10_INI  = CNT_W'(COIN10_INIT);

  disp_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       chg_q, chg_d;
  logic             sel10_q, sel10_d;   // current eject uses the 10-unit ejector
  logic             two_q, two_d;       // a second 5-unit coin still follows
  logic [CNT_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] c5_q, c5_d;
  logic [CNT_W-1:0] c10_q, c10_d;
  logic             ovf_q;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  req_t             w_head;
  logic [1:0]       w_plan_code;
  logic             w_plan_ok;
  logic             w_plan_10;
  logic             w_plan_two;
  logic             w_strobe_win;

  assign w_push = out_i || (change_i == CHG_5) || (change_i == CHG_10);
  assign w_pop  = (state_q == ST_LOAD);

  iiitb_vm_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .wdata_i (make_req(out_i, change_i)),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Choose the coin mix for the pending change from current stock.
  always_comb begin
    w_plan_code = (state_q == ST_LOAD) ? w_head.chg : chg_q;
    w_plan_ok   = 1'b0;
    w_plan_10   = 1'b0;
    w_plan_two  = 1'b0;
    case (w_plan_code)
      CHG_10: begin
        if (c10_q != '0) begin
          w_plan_ok = 1'b1;
          w_plan_10 = 1'b1;
        end else if (c5_q >= C_TWO) begin
          w_plan_ok  = 1'b1;
          w_plan_two = 1'b1;
        end
      end
      CHG_5:   w_plan_ok = (c5_q != '0);
      default: w_plan_ok = 1'b0;
    endcase
  end

  // Next-state, wait counter and inventory updates; refill overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg_d   = chg_q;
    sel10_d = sel10_q;
    two_d   = two_q;
    prod_d  = prod_q;
    c5_d    = c5_q;
    c10_d   = c10_q;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        chg_d   = w_head.chg;
        cnt_d   = '0;
        sel10_d = w_plan_10;
        two_d   = w_plan_two;
        if (w_head.vend) begin
          state_d = (prod_q == '0) ? ST_FAULT : ST_PROD;
        end else if (w_head.chg != CHG_NONE) begin
          state_d = w_plan_ok ? ST_CHG : ST_FAULT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROD: begin
        if (prod_sense_i) begin
          if (prod_q != '0) prod_d = prod_q - C_ONE;
          cnt_d   = '0;
          sel10_d = w_plan_10;
          two_d   = w_plan_two;
          if (chg_q == CHG_NONE) state_d = ST_IDLE;
          else                   state_d = w_plan_ok ? ST_CHG : ST_FAULT;
        end else if (cnt_q == C_T_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHG: begin
        if (coin_sense_i) begin
          if (sel10_q) begin
            if (c10_q != '0) c10_d = c10_q - C_ONE;
          end else begin
            if (c5_q != '0) c5_d = c5_q - C_ONE;
          end
          cnt_d = '0;
          if (two_q) two_d   = 1'b0;
          else       state_d = ST_IDLE;
        end else if (cnt_q == C_T_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    if (refill_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      prod_d  = C_PROD_INI;
      c5_d    = C_C5_INI;
      c10_d   = C_C10_INI;
    end
  end

  // State, counters and sticky overflow registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chg_q   <= CHG_NONE;
      sel10_q <= 1'b0;
      two_q   <= 1'b0;
      prod_q  <= C_PROD_INI;
      c5_q    <= C_C5_INI;
      c10_q   <= C_C10_INI;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      sel10_q <= sel10_d;
      two_q   <= two_d;
      prod_q  <= prod_d;
      c5_q    <= c5_d;
      c10_q   <= c10_d;
      if (w_push && w_full && !w_pop) ovf_q <= 1'b1;
    end
  end

  assign w_strobe_win   = (cnt_q < C_PULSE);
  assign prod_motor_o   = (state_q == ST_PROD) && w_strobe_win;
  assign coin5_eject_o  = (state_q == ST_CHG) && !sel10_q && w_strobe_win;
  assign coin10_eject_o = (state_q == ST_CHG) && sel10_q && w_strobe_win;
  assign busy_o         = (state_q != ST_IDLE) || !w_empty;
  assign overflow_o     = ovf_q;
  assign fault_o        = (state_q == ST_FAULT);
  assign prod_empty_o   = (prod_q == '0);
  assign prod_count_o   = prod_q;
  assign coin5_count_o  = c5_q;
  assign coin10_count_o = c10_q;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_vm_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_iiitb_vm_dispenser
// Purpose  : Self-checking bench for the vending dispenser back end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iiitb_vm_dispenser;

  logic       clock = 1'b0;
  logic       reset, out, prod_sense, coin_sense, refill;
  logic [1:0] change;
  logic       prod_motor, coin5_eject, coin10_eject, busy, overflow, fault, prod_empty;
  logic [7:0] prod_count, coin5_count, coin10_count;

  iiitb_vm_dispenser dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .out_i          (out),
    .change_i       (change),
    .prod_sense_i   (prod_sense),
    .coin_sense_i   (coin_sense),
    .refill_i       (refill),
    .prod_motor_o   (prod_motor),
    .coin5_eject_o  (coin5_eject),
    .coin10_eject_o (coin10_eject),
    .busy_o         (busy),
    .overflow_o     (overflow),
    .fault_o        (fault),
    .prod_empty_o   (prod_empty),
    .prod_count_o   (prod_count),
    .coin5_count_o  (coin5_count),
    .coin10_count_o (coin10_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       vend;
    logic [1:0] chg;
    int         n_prod;
    int         n_c10;
    int         n_c5;
    int         exp_p;
    int         exp_c5;
    int         exp_c10;
  } vec_t;

  vec_t tbl [6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic strobe_of(input int k);
    return (k == 1) ? prod_motor : (k == 2) ? coin5_eject : coin10_eject;
  endfunction

  // kind: 0 no strobe, 1 product, 2 coin5, 3 coin10
  task automatic get_strobe(output int kind, output int width);
    kind  = 0;
    width = 0;
    for (int i = 0; i < 60 && kind == 0; i++) begin
      if (prod_motor)        kind = 1;
      else if (coin5_eject)  kind = 2;
      else if (coin10_eject) kind = 3;
      if (kind == 0) @(negedge clock);
    end
    if (kind != 0) begin
      while (strobe_of(kind) && width < 2000) begin
        width++;
        @(negedge clock);
      end
    end
  endtask

  task automatic expect_item(input string tag, input int exp_kind, input bit do_sense,
                             input bit chk_w);
    int k, w;
    get_strobe(k, w);
    check({tag, "_kind"}, k, exp_kind);
    if (chk_w) check({tag, "_width"}, w, 8);
    if (do_sense) begin
      if (exp_kind == 1) prod_sense = 1'b1;
      else               coin_sense = 1'b1;
      @(negedge clock);
      prod_sense = 1'b0;
      coin_sense = 1'b0;
    end
  endtask

  task automatic push(input logic v, input logic [1:0] c);
    out    = v;
    change = c;
    @(negedge clock);
    out    = 1'b0;
    change = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clock);
  endtask

  task automatic check_counts(input string tag, input int p, input int c5, input int c10);
    check({tag, "_prod"}, prod_count, p);
    check({tag, "_coin5"}, coin5_count, c5);
    check({tag, "_coin10"}, coin10_count, c10);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    push(v.vend, v.chg);
    for (int i = 0; i < v.n_prod; i++) expect_item({tag, "_p"}, 1, 1'b1, 1'b1);
    for (int i = 0; i < v.n_c10; i++)  expect_item({tag, "_c10"}, 3, 1'b1, 1'b1);
    for (int i = 0; i < v.n_c5; i++)   expect_item({tag, "_c5"}, 2, 1'b1, 1'b1);
    wait_idle();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fault"}, fault, 0);
    check_counts(tag, v.exp_p, v.exp_c5, v.exp_c10);
  endtask

  initial begin
    int   t;
    logic seen;
    vec_t v;

    // vend, chg, n_prod, n_c10, n_c5, prod, coin5, coin10 after service
    tbl[0] = '{1'b1, 2'b10, 1, 1, 0, 14, 32, 15};
    tbl[1] = '{1'b1, 2'b00, 1, 0, 0, 13, 32, 15};
    tbl[2] = '{1'b0, 2'b01, 0, 0, 1, 13, 31, 15};
    tbl[3] = '{1'b1, 2'b11, 1, 0, 0, 12, 31, 15};
    tbl[4] = '{1'b0, 2'b10, 0, 1, 0, 12, 31, 14};
    tbl[5] = '{1'b1, 2'b01, 1, 0, 1, 11, 30, 14};

    reset = 1'b1; out = 1'b0; change = 2'b00;
    prod_sense = 1'b0; coin_sense = 1'b0; refill = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_strobes", {prod_motor, coin5_eject, coin10_eject}, 0);
    check("rst_flags", {busy, overflow, fault, prod_empty}, 0);
    check_counts("rst", 16, 32, 16);

    // First strobe two clocks after the push
    push(1'b1, 2'b00);
    check("lat_c1", prod_motor, 0);
    @(negedge clock);
    check("lat_c2", prod_motor, 0);
    @(negedge clock);
    check("lat_c3", prod_motor, 1);
    expect_item("lat", 1, 1'b1, 1'b1);
    wait_idle();
    check_counts("lat", 15, 32, 16);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Five requests while busy: four buffered, fifth dropped
    push(1'b1, 2'b00);
    @(negedge clock);
    push(1'b1, 2'b00);
    push(1'b0, 2'b01);
    push(1'b0, 2'b10);
    push(1'b1, 2'b01);
    push(1'b0, 2'b01);
    check("ovf_flag", overflow, 1);
    expect_item("ovf_x", 1, 1'b1, 1'b0);
    expect_item("ovf_a", 1, 1'b1, 1'b1);
    expect_item("ovf_b", 2, 1'b1, 1'b1);
    expect_item("ovf_c", 3, 1'b1, 1'b1);
    expect_item("ovf_d1", 1, 1'b1, 1'b1);
    expect_item("ovf_d2", 2, 1'b1, 1'b1);
    wait_idle();
    check("ovf_busy", busy, 0);
    check_counts("ovf", 8, 28, 13);

    // Drain the 10-unit coins, then ten is paid as two fives
    for (int i = 0; i < 13; i++) begin
      v = '{1'b0, 2'b10, 0, 1, 0, 8, 28, 12 - i};
      run_vec($sformatf("drain%0d", i), v);
    end
    v = '{1'b0, 2'b10, 0, 0, 2, 8, 26, 0};
    run_vec("two5", v);

    // Missing product sense: fault after the timeout
    push(1'b1, 2'b00);
    expect_item("tmo", 1, 1'b0, 1'b1);
    t = 8;
    while (!fault && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check("tmo_cycles", t, 1024);
    check("tmo_strobes", {prod_motor, coin5_eject, coin10_eject}, 0);
    check("tmo_prod", prod_count, 8);
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    check("refill_fault", fault, 0);
    check_counts("refill", 16, 32, 16);

    // Empty product stock
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 2'b00, 1, 0, 0, 15 - i, 32, 16};
      run_vec($sformatf("pdrain%0d", i), v);
    end
    check("pempty_flag", prod_empty, 1);
    push(1'b1, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= prod_motor;
      @(negedge clock);
    end
    check("pempty_motor", seen, 0);
    check("pempty_fault", fault, 1);
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    check("pempty_refill", fault, 0);

    // Reset during a coin strobe with a request still queued
    push(1'b1, 2'b01);
    push(1'b1, 2'b00);
    expect_item("mid_p", 1, 1'b1, 1'b1);
    check("mid_prod", prod_count, 15);
    for (int i = 0; i < 20 && !coin5_eject; i++) @(negedge clock);
    check("mid_c5_on", coin5_eject, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_strobe", coin5_eject, 0);
    check("mid_busy", busy, 0);
    check("mid_ovf", overflow, 0);
    check_counts("mid", 16, 32, 16);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= prod_motor | coin5_eject | coin10_eject | busy;
      @(negedge clock);
    end
    check("mid_quiet", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
